// File: rtl/uart_tx.sv
// Serial transmitter: 1 start bit, FRAME_WIDTH data bits LSB first, 1 stop bit.
// All outputs are registered and derived from the next state, so tx moves one edge after the decision.
module uart_tx #(
    parameter int FRAME_WIDTH  = 8,
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_en,
    input  logic [FRAME_WIDTH-1:0] data,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FRAME_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       baud_reg, baud_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [FRAME_WIDTH-1:0] data_reg, data_next;
    logic                   tx_reg, tx_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic                   bit_end;

    assign bit_end = (baud_reg == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = bit_end ? '0 : baud_reg + 1'b1;
        idx_next   = idx_reg;
        data_next  = data_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // Baud counter is parked at zero so START gets a full bit period.
                baud_next = '0;
                if (tx_en) begin
                    state_next = START;
                    data_next  = data;
                    idx_next   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_reg == IDX_MAX) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = data_next[idx_next];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: each frame is compared cycle by cycle against
// the expected line waveform {start=0, data LSB first, stop=1}, each bit CPB cycles long.
module tb_uart_tx;

    localparam int FW  = 8;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_en;
    logic [FW-1:0] data;
    logic          tx;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(.FRAME_WIDTH(FW), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_en (tx_en),
        .data  (data),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Request a frame in IDLE; returns at the first start-bit cycle.
    task automatic begin_frame(input logic [FW-1:0] w);
        @(negedge clk);
        tx_en = 1'b1;
        data  = w;
        @(posedge clk);
        #1;
    endtask

    // Starts at the first start-bit cycle, ends at the done cycle.
    task automatic run_frame(input logic [FW-1:0] w, input bit keep_en, input logic [FW-1:0] mid_data);
        logic exp_bits [FW+2];
        int   fail_before;
        fail_before = n_fail;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < FW; i++) exp_bits[i+1] = w[i];
        exp_bits[FW+1] = 1'b1;
        for (int b = 0; b < FW + 2; b++) begin
            for (int c = 0; c < CPB; c++) begin
                n_checks++;
                if (tx !== exp_bits[b] || busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL frame_bit word=%h bit=%0d cyc=%0d got tx=%b busy=%b done=%b want tx=%b busy=1 done=0",
                             w, b, c, tx, busy, done, exp_bits[b]);
                end
                if (b == 0 && c == 0 && !keep_en) tx_en = 1'b0;
                if (b == 4 && c == 1) data = mid_data;
                if (!(b == FW + 1 && c == CPB - 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_done word=%h got done=%b busy=%b tx=%b want done=1 busy=0 tx=1",
                     w, done, busy, tx);
        end
        $display("frame word=%h cycles=%0d result=%s", w, (FW + 2) * CPB,
                 (n_fail == fail_before) ? "ok" : "bad");
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got tx=%b busy=%b done=%b want 1/0/0", i, tx, busy, done);
            end
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_idle();
        tx_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data = FW'($urandom);
            @(posedge clk);
            #1;
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle cyc=%0d got tx=%b busy=%b done=%b want 1/0/0", i, tx, busy, done);
            end
        end
        $display("idle 20 cycles checked");
    endtask

    task automatic test_fixed_frames();
        begin_frame(8'hEC);
        run_frame(8'hEC, 1'b0, 8'h00);
        begin_frame(8'h6D);
        run_frame(8'h6D, 1'b0, 8'hFF);
    endtask

    task automatic test_random_frames();
        logic [FW-1:0] w;
        for (int k = 0; k < 6; k++) begin
            w = FW'($urandom);
            begin_frame(w);
            run_frame(w, 1'b0, FW'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] a;
        logic [FW-1:0] b;
        a = FW'($urandom);
        b = ~a;
        begin_frame(a);
        run_frame(a, 1'b1, b);
        // tx_en still high in the done cycle: next edge must start the new word.
        @(posedge clk);
        #1;
        run_frame(b, 1'b0, a);
    endtask

    task automatic test_mid_frame_reset();
        logic [FW-1:0] w;
        logic [FW-1:0] w2;
        w  = 8'hA5;
        w2 = 8'h3C;
        begin_frame(w);
        for (int i = 0; i < 3 * CPB + 2; i++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_busy got busy=%b want 1", busy);
        end
        rst   = 1'b1;
        tx_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset cyc=%0d got tx=%b busy=%b done=%b want 1/0/0", i, tx, busy, done);
            end
        end
        rst  = 1'b0;
        data = w2;
        @(posedge clk);
        #1;
        $display("mid-frame reset applied, restarting with word=%h", w2);
        run_frame(w2, 1'b0, 8'h00);
    endtask

    initial begin
        rst   = 1'b1;
        tx_en = 1'b0;
        data  = '0;
        test_reset();
        test_idle();
        test_fixed_frames();
        test_random_frames();
        test_back_to_back();
        test_mid_frame_reset();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter FRAME_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 10417: clock cycles per serial bit (100 MHz clock, 9600 baud).
REQ-003 clk  input  1  sole clock; all logic updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tx_en  input  1  transmit request, level-sensitive, sampled only in IDLE.
REQ-006 data  input  FRAME_WIDTH  parallel word to send; captured at frame start.
REQ-007 tx  output  1  serial line; idles high; registered.
REQ-008 busy  output  1  high while a frame is on the line; registered.
REQ-009 done  output  1  one-cycle pulse marking frame completion; registered.

Function
REQ-010 The frame format SHALL be 1 start bit (0), then FRAME_WIDTH data bits LSB first, then 1 stop bit (1); no parity.
REQ-011 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-012 IDLE: tx=1 and busy=0; on an edge with tx_en=1, the FSM SHALL load data into a shift/hold register, clear the bit and baud counters, and go to START.
REQ-013 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-014 DATA: tx=data_reg[index] for CLKS_PER_BIT cycles per bit; index increments 0..FRAME_WIDTH-1; after the last bit, go to STOP.
REQ-015 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for exactly that one following cycle.
REQ-016 busy SHALL be 1 in every cycle spent in START, DATA or STOP, and 0 in IDLE.
REQ-017 Latency: tx SHALL fall in the cycle after the edge that samples tx_en=1 in IDLE.
REQ-018 Total frame duration from first start-bit cycle to the done cycle SHALL be (FRAME_WIDTH+2)*CLKS_PER_BIT cycles.
REQ-019 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL count 0..CLKS_PER_BIT-1 and wrap at each bit boundary.
REQ-020 Changes on data or tx_en during a frame SHALL have no effect on the frame in progress.
REQ-021 If tx_en is still 1 in the done cycle (IDLE), the next edge SHALL start a new frame with the current data; the minimum gap between frames is therefore one idle-high cycle.
REQ-022 tx_en=0 in IDLE SHALL keep the block in IDLE indefinitely with tx=1.
REQ-023 done and busy SHALL never both be 1 in the same cycle.

Reset
REQ-024 When rst=1 at a clock edge, the next state SHALL be IDLE with tx=1, busy=0, done=0, all counters and the data register cleared.
REQ-025 rst SHALL take priority over tx_en and over any in-progress frame; a reset mid-frame aborts it, and no done pulse is produced.
REQ-026 After rst deasserts, the first edge with tx_en=1 SHALL start a fresh frame per REQ-012.

Verification
REQ-027 Reset held 2 cycles, tx_en=0 -> tx=1, busy=0, done=0 throughout.
REQ-028 tx_en=1, data=0xEC, CLKS_PER_BIT=10417 -> line bits 0,0,0,1,1,0,1,1,1,1, each lasting 10417 cycles; done pulses 104170 cycles after the start bit begins (~1.0417 ms at 100 MHz).
REQ-029 Reset then tx_en=1, data=0x6D -> line bits 0,1,0,1,1,0,1,1,0,1; busy=1 for the whole frame; done is a single-cycle pulse with busy=0.
REQ-030 CLKS_PER_BIT=4, tx_en held 1, data changed mid-frame -> the first frame carries the originally captured word; the second frame starts one cycle after done and carries the new word.
REQ-031 CLKS_PER_BIT=4, rst=1 asserted during DATA -> tx=1 and busy=0 on the next cycle; no done pulse; a new frame starts when rst=0 and tx_en=1.
